booth_prod_acc: RTL

Signed product accumulator directly downstream of `booth_mult`. It captures each finished product on the multiplier's `done` strobe and sums LEN consecutive products into a guard-bit-widened result. It presents the result on a valid/ready output handshake for the dot-product / FIR datapath. Back-pressure is reported upstream through `in_ready`. Products arriving while the block cannot accept them are flagged as a sticky error.

---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_prod_acc.sv | 111 +++++++++++
 2 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the booth multiplier datapath: default operand width,
// derived product/accumulator widths and the accumulator FSM state encoding.
package booth_pkg;

    localparam int D_IN_DEF = 8;

    function automatic int prod_width(input int d_in);
        return 2 * d_in;
    endfunction

    // $clog2(1) is 0, so a single-product build keeps the bare product width
    function automatic int acc_width(input int d_in, input int len);
        return 2 * d_in + $clog2(len);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

endpackage

// File: rtl/booth_prod_acc.sv
// Sums LEN consecutive signed products from booth_mult into a guard-bit-widened
// result and offers it on a valid/ready handshake, flagging dropped products.
module booth_prod_acc
    import booth_pkg::*;
#(
    parameter int  D_IN  = D_IN_DEF,
    parameter int  LEN   = 4,
    localparam int PW    = prod_width(D_IN),
    localparam int ACC_W = acc_width(D_IN, LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PW-1:0]    in_prod,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             busy,
    output logic             drop_err
);

    localparam int CNT_W = $clog2(LEN + 1);

    acc_state_t       state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             drop_next;
    logic             accept, xfer;
    logic [ACC_W-1:0] prod_ext;

    assign prod_ext  = ACC_W'($signed(in_prod));
    assign cnt_inc   = cnt + CNT_W'(1);

    assign out_valid = (state == HOLD);
    assign busy      = (state == ACC);
    assign in_ready  = (state != HOLD) | out_ready;
    assign out_sum   = acc;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            drop_err <= drop_next;
        end
    end

    // clear outranks every handshake, so a coincident product is neither summed nor flagged
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        drop_next  = drop_err;

        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            drop_next  = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                drop_next = 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc_next   = prod_ext;
                        cnt_next   = CNT_W'(1);
                        state_next = (LEN == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_next = acc + prod_ext;
                        cnt_next = cnt_inc;
                        if (cnt_inc == CNT_W'(LEN)) begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    // a product arriving with the transfer restarts accumulation without a bubble
                    if (xfer) begin
                        if (accept) begin
                            acc_next   = prod_ext;
                            cnt_next   = CNT_W'(1);
                            state_next = (LEN == 1) ? HOLD : ACC;
                        end else begin
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
